// File: rtl/sdram_fifo_scheduler.sv
// Memory-side sequencer: pops one command at a time from the command FIFO and drives a single request into the SDRAM core.
// Define SDRAM_SCHED_REFRESH_EN to interleave periodic auto-refresh requests between commands.
module sdram_fifo_scheduler #(
    parameter int ADDR_WIDTH                = 25,
    parameter int REFRESH_PERIOD            = 780,
    parameter int SDRAM_CMD_FIFO_DATA_WIDTH = 36
) (
    input  logic                                 HCLK,
    input  logic                                 HRESET,
    output logic                                 CFIFO_REN,
    input  logic [SDRAM_CMD_FIFO_DATA_WIDTH-1:0] CFIFO_RDATA,
    input  logic                                 CFIFO_REMPTY,
    output logic                                 WFIFO_REN,
    input  logic [31:0]                          WFIFO_RDATA,
    input  logic                                 WFIFO_REMPTY,
    output logic                                 RFIFO_WEN,
    output logic [31:0]                          RFIFO_WDATA,
    input  logic                                 RFIFO_WFULL,
    output logic                                 MEM_REQ,
    output logic                                 MEM_WRITE,
    output logic                                 MEM_REFRESH,
    output logic [ADDR_WIDTH-1:0]                MEM_ADDR,
    output logic [3:0]                           MEM_BE,
    output logic [31:0]                          MEM_WDATA,
    input  logic                                 MEM_ACK,
    input  logic [31:0]                          MEM_RDATA,
    input  logic                                 MEM_RVALID,
    output logic                                 BUSY,
    output logic [2:0]                           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WDATA   = 3'd1,
        S_WR_REQ  = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RD_PUSH = 3'd5,
        S_REF     = 3'd6
    } state_t;

    state_t state;
    logic   take_ref;
    logic   unused_bits;

    function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'd0:    be_decode = 4'b0001 << lo;
            3'd1:    be_decode = lo[1] ? 4'b1100 : 4'b0011;
            default: be_decode = 4'b1111;
        endcase
    endfunction

    // Handshakes: MEM_REQ stays high with MEM_ADDR/MEM_BE/MEM_WDATA frozen until the
    // single-cycle MEM_ACK; a FIFO strobe (REN/WEN) fires only in a cycle where the
    // matching EMPTY/FULL flag is low, and that cycle is the transfer.
    assign CFIFO_REN = (state == S_IDLE) && !take_ref && !CFIFO_REMPTY;
    assign WFIFO_REN = (state == S_WDATA) && !WFIFO_REMPTY;
    assign RFIFO_WEN = (state == S_RD_PUSH) && !RFIFO_WFULL;
    assign MEM_REQ   = (state == S_WR_REQ) || (state == S_RD_REQ) || (state == S_REF);
    assign MEM_WRITE = (state == S_WR_REQ);
    assign BUSY      = (state != S_IDLE);
    assign dbg_state = state;

    assign unused_bits = ^{CFIFO_RDATA[31:ADDR_WIDTH+2], ((REFRESH_PERIOD % 2) == 1)};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= S_IDLE;
            MEM_ADDR    <= '0;
            MEM_BE      <= '0;
            MEM_WDATA   <= '0;
            RFIFO_WDATA <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_ref) begin
                        state <= S_REF;
                    end else if (!CFIFO_REMPTY) begin
                        MEM_ADDR <= CFIFO_RDATA[ADDR_WIDTH+1:2];
                        MEM_BE   <= be_decode(CFIFO_RDATA[34:32], CFIFO_RDATA[1:0]);
                        state    <= CFIFO_RDATA[35] ? S_WDATA : S_RD_REQ;
                    end
                end
                S_WDATA: begin
                    if (!WFIFO_REMPTY) begin
                        MEM_WDATA <= WFIFO_RDATA;
                        state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (MEM_ACK) state <= S_IDLE;
                end
                S_RD_REQ: begin
                    if (MEM_ACK) state <= S_RD_DATA;
                end
                // Only entered after the ACK cycle, so an RVALID coincident with ACK is ignored.
                S_RD_DATA: begin
                    if (MEM_RVALID) begin
                        RFIFO_WDATA <= MEM_RDATA;
                        state       <= S_RD_PUSH;
                    end
                end
                S_RD_PUSH: begin
                    if (!RFIFO_WFULL) state <= S_IDLE;
                end
`ifdef SDRAM_SCHED_REFRESH_EN
                S_REF: begin
                    if (MEM_ACK) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SDRAM_SCHED_REFRESH_EN
    localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    logic [CNT_W-1:0] ref_cnt;
    logic             ref_pending;
    logic             ref_wrap;

    assign ref_wrap    = (ref_cnt == CNT_W'(REFRESH_PERIOD - 1));
    assign take_ref    = ref_pending;
    assign MEM_REFRESH = (state == S_REF);

    // The ACK clear wins over a coincident wrap: a wrap while still pending is dropped.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + CNT_W'(1);
            if ((state == S_REF) && MEM_ACK)
                ref_pending <= 1'b0;
            else if (ref_wrap)
                ref_pending <= 1'b1;
        end
    end
`else
    assign take_ref    = 1'b0;
    assign MEM_REFRESH = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_fifo_scheduler.sv
// Bench for sdram_fifo_scheduler: show-ahead FIFO models, a small SDRAM core model and a request/read-data scoreboard.
module tb_sdram_fifo_scheduler;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        CFIFO_REN;
    logic [35:0] CFIFO_RDATA;
    logic        CFIFO_REMPTY;
    logic        WFIFO_REN;
    logic [31:0] WFIFO_RDATA;
    logic        WFIFO_REMPTY;
    logic        RFIFO_WEN;
    logic [31:0] RFIFO_WDATA;
    logic        RFIFO_WFULL;
    logic        MEM_REQ;
    logic        MEM_WRITE;
    logic        MEM_REFRESH;
    logic [24:0] MEM_ADDR;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        MEM_RVALID;
    logic        BUSY;
    logic [2:0]  dbg_state;

    sdram_fifo_scheduler #(.ADDR_WIDTH(25), .REFRESH_PERIOD(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .CFIFO_REN(CFIFO_REN), .CFIFO_RDATA(CFIFO_RDATA), .CFIFO_REMPTY(CFIFO_REMPTY),
        .WFIFO_REN(WFIFO_REN), .WFIFO_RDATA(WFIFO_RDATA), .WFIFO_REMPTY(WFIFO_REMPTY),
        .RFIFO_WEN(RFIFO_WEN), .RFIFO_WDATA(RFIFO_WDATA), .RFIFO_WFULL(RFIFO_WFULL),
        .MEM_REQ(MEM_REQ), .MEM_WRITE(MEM_WRITE), .MEM_REFRESH(MEM_REFRESH),
        .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID),
        .BUSY(BUSY), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired before end of test");
        $fatal(1, "watchdog");
    end

    // FIFO contents, scoreboard and memory images
    logic [35:0] cq[$];
    logic [31:0] wq[$];
    logic [61:0] exp_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] core_mem[logic [24:0]];
    logic [31:0] ref_mem[logic [24:0]];

    int n_chk = 0, n_bad = 0;
    int cyc = 0, ack_lat = 1, rv_dly = 1;
    int req_cnt = 0, rv_cnt = 0, hi_cnt = 0, last_hi_len = 0;
    int n_req = 0, n_ack = 0, n_rv = 0, n_push = 0, n_wpop = 0, n_ref = 0, n_flag_bad = 0;
    int req_cyc = 0, ack_cyc = 0, rv_cyc = 0, push_cyc = 0, w_pop_cyc = 0, last_cpop = 0;
    int last_ref_cyc = -1, ref_gap_bad = 0;
    int cpop_q[$];
    logic        c_pop = 1'b0, w_pop = 1'b0;
    logic [24:0] rv_addr;
    logic [60:0] req_snap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [24:0] a);
        return 32'hA5000000 ^ {7'd0, a};
    endfunction

    task automatic upd_fifos();
        CFIFO_REMPTY = (cq.size() == 0);
        CFIFO_RDATA  = (cq.size() != 0) ? cq[0] : 36'h0;
        WFIFO_REMPTY = (wq.size() == 0);
        WFIFO_RDATA  = (wq.size() != 0) ? wq[0] : 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #2;
    endtask

    // driver: queue one command, its write data and the expected core request / read result
    task automatic push_cmd(input logic w, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic with_data);
        logic [24:0] wa;
        logic [3:0]  be;
        wa = addr[26:2];
        case (size)
            3'd0:    be = 4'b0001 << addr[1:0];
            3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        cq.push_back({w, size, addr});
        if (w && with_data) wq.push_back(wd);
        exp_q.push_back({w, wa, be, w ? wd : 32'h0});
        if (!ref_mem.exists(wa)) ref_mem[wa] = init_word(wa);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
        end else begin
            exp_rd_q.push_back(ref_mem[wa]);
        end
        upd_fifos();
    endtask

    task automatic drain(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (cq.size() == 0 && wq.size() == 0 && exp_q.size() == 0 &&
                exp_rd_q.size() == 0 && !BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_drain"}, 64'(ok), 64'd1);
        step(1);
    endtask

    // core + FIFO model: observes at negedge, applies pops just after the next posedge
    initial begin : core_model
        MEM_ACK = 1'b0;
        MEM_RVALID = 1'b0;
        MEM_RDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            cyc++;
            MEM_ACK = 1'b0;
            MEM_RVALID = 1'b0;
            if (HRESET) begin
                req_cnt = 0;
                rv_cnt  = 0;
                hi_cnt  = 0;
            end else begin
                if ((CFIFO_REN && CFIFO_REMPTY) || (WFIFO_REN && WFIFO_REMPTY) ||
                    (RFIFO_WEN && RFIFO_WFULL))
                    n_flag_bad++;
                if (MEM_REQ) hi_cnt++;
                else if (hi_cnt != 0) begin
                    last_hi_len = hi_cnt;
                    hi_cnt = 0;
                end
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        if (!core_mem.exists(rv_addr)) core_mem[rv_addr] = init_word(rv_addr);
                        MEM_RVALID = 1'b1;
                        MEM_RDATA  = core_mem[rv_addr];
                        rv_cyc = cyc;
                        n_rv++;
                    end
                end
                if (MEM_REQ) begin
                    if (req_cnt == 0) begin
                        req_cyc  = cyc;
                        req_snap = {MEM_ADDR, MEM_BE, MEM_WDATA};
                        if (MEM_REFRESH) begin
                            if (last_ref_cyc >= 0 && (cyc - last_ref_cyc) < 16) ref_gap_bad++;
                            last_ref_cyc = cyc;
                        end else begin
                            n_req++;
                            if (exp_q.size() == 0) chk("req_unexpected", 64'd1, 64'd0);
                            else chk("req", {2'b0, MEM_WRITE, MEM_ADDR, MEM_BE,
                                             MEM_WRITE ? MEM_WDATA : 32'h0}, {2'b0, exp_q.pop_front()});
                        end
                    end
                    req_cnt++;
                    if (req_cnt >= ack_lat) begin
                        chk("req_hold", {3'b0, MEM_ADDR, MEM_BE, MEM_WDATA}, {3'b0, req_snap});
                        MEM_ACK = 1'b1;
                        req_cnt = 0;
                        ack_cyc = cyc;
                        n_ack++;
                        if (MEM_REFRESH) begin
                            n_ref++;
                        end else if (MEM_WRITE) begin
                            if (!core_mem.exists(MEM_ADDR)) core_mem[MEM_ADDR] = init_word(MEM_ADDR);
                            for (int b = 0; b < 4; b++)
                                if (MEM_BE[b]) core_mem[MEM_ADDR][8*b +: 8] = MEM_WDATA[8*b +: 8];
                        end else begin
                            rv_cnt  = rv_dly;
                            rv_addr = MEM_ADDR;
                        end
                    end
                end
                if (RFIFO_WEN) begin
                    n_push++;
                    push_cyc = cyc;
                    if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
                    else chk("rd_data", 64'(RFIFO_WDATA), 64'(exp_rd_q.pop_front()));
                end
                c_pop = CFIFO_REN;
                w_pop = WFIFO_REN;
                if (c_pop) begin
                    cpop_q.push_back(cyc);
                    last_cpop = cyc;
                end
                if (w_pop) begin
                    n_wpop++;
                    w_pop_cyc = cyc;
                end
            end
            @(posedge HCLK);
            #1;
            if (c_pop && cq.size() != 0) cq.delete(0);
            if (w_pop && wq.size() != 0) wq.delete(0);
            c_pop = 1'b0;
            w_pop = 1'b0;
            upd_fifos();
        end
    end

    // stimulus
    initial begin : stim
        int r0, p0, w0, drop_at, push_at;
        logic [31:0] d1, d2;
        logic got;
        RFIFO_WFULL = 1'b0;
        upd_fifos();
        core_mem[25'h0] = 32'h11223344;
        ref_mem[25'h0]  = 32'h11223344;

        step(3);
        chk("rst_ctl", {57'd0, CFIFO_REN, WFIFO_REN, RFIFO_WEN, MEM_REQ, MEM_WRITE, MEM_REFRESH, BUSY}, 64'd0);
        chk("rst_addr_be", {35'd0, MEM_ADDR, MEM_BE}, 64'd0);
        chk("rst_data", {MEM_WDATA, RFIFO_WDATA}, 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        HRESET = 1'b0;
        step(2);

        // write word
        ack_lat = 3;
        w0 = n_wpop;
        push_cmd(1'b1, 3'd2, 32'h0000_0104, 32'hDEADBEEF, 1'b1);
        drain("wr_word", 50);
        chk("wr_req_len", 64'(last_hi_len), 64'd3);
        chk("wr_wpop_once", 64'(n_wpop - w0), 64'd1);
        chk("wr_lat_wren", 64'(w_pop_cyc - last_cpop), 64'd1);
        chk("wr_lat_req", 64'(req_cyc - last_cpop), 64'd2);
        chk("wr_addr", 64'(MEM_ADDR), 64'h41);
        chk("wr_be_wdata", {28'd0, MEM_BE, MEM_WDATA}, {28'd0, 4'b1111, 32'hDEADBEEF});

        // read byte
        ack_lat = 1;
        rv_dly = 2;
        push_cmd(1'b0, 3'd0, 32'h0000_0003, 32'h0, 1'b1);
        drain("rd_byte", 50);
        chk("rd_lat_req", 64'(req_cyc - last_cpop), 64'd1);
        chk("rd_be", 64'(MEM_BE), 64'b1000);
        chk("rd_rv_after_ack", 64'(rv_cyc - ack_cyc), 64'd2);
        chk("rd_push_lat", 64'(push_cyc - rv_cyc), 64'd1);
        chk("rd_rdata", 64'(RFIFO_WDATA), 64'h11223344);

        // back-pressure: write data late, then read FIFO full
        r0 = n_req;
        w0 = n_wpop;
        push_cmd(1'b1, 3'd2, 32'h0000_0200, 32'hCAFE0001, 1'b0);
        step(5);
        chk("bp_wr_noreq", 64'(n_req - r0), 64'd0);
        chk("bp_wr_nowpop", 64'(n_wpop - w0), 64'd0);
        wq.push_back(32'hCAFE0001);
        upd_fifos();
        push_at = cyc;
        drain("bp_wr", 50);
        chk("bp_wr_wpop_lat", 64'(w_pop_cyc - push_at), 64'd1);
        chk("bp_wr_req", 64'(n_req - r0), 64'd1);

        rv_dly = 1;
        RFIFO_WFULL = 1'b1;
        p0 = n_push;
        r0 = n_rv;
        push_cmd(1'b0, 3'd2, 32'h0000_0200, 32'h0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (n_rv != r0) begin got = 1'b1; break; end
        end
        chk("bp_rd_rvalid", 64'(got), 64'd1);
        step(4);
        chk("bp_rd_held", 64'(n_push - p0), 64'd0);
        RFIFO_WFULL = 1'b0;
        drop_at = cyc;
        drain("bp_rd", 50);
        chk("bp_rd_push", 64'(n_push - p0), 64'd1);
        chk("bp_rd_push_lat", 64'(push_cyc - drop_at), 64'd1);

        // ordering through the core model
        ack_lat = $urandom_range(1, 3);
        rv_dly  = $urandom_range(1, 3);
        d1 = $urandom();
        d2 = $urandom();
        r0 = n_req;
        push_cmd(1'b1, 3'd2, 32'h0000_0010, d1, 1'b1);
        push_cmd(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b1);
        push_cmd(1'b1, 3'd2, 32'h0000_0020, d2, 1'b1);
        drain("ord", 100);
        chk("ord_nreq", 64'(n_req - r0), 64'd3);
        chk("ord_rdata", 64'(RFIFO_WDATA), 64'(d1));

        // throughput with zero core latency
        ack_lat = 1;
        rv_dly  = 1;
        cpop_q.delete();
        push_cmd(1'b1, 3'd2, 32'h0000_0040, 32'h01020304, 1'b1);
        push_cmd(1'b1, 3'd2, 32'h0000_0044, 32'h05060708, 1'b1);
        push_cmd(1'b0, 3'd2, 32'h0000_0040, 32'h0, 1'b1);
        push_cmd(1'b0, 3'd2, 32'h0000_0044, 32'h0, 1'b1);
        drain("tp", 100);
        if (cpop_q.size() == 4) begin
            chk("tp_wr_wr", 64'(cpop_q[1] - cpop_q[0]), 64'd3);
            chk("tp_wr_rd", 64'(cpop_q[2] - cpop_q[1]), 64'd3);
            chk("tp_rd_rd", 64'(cpop_q[3] - cpop_q[2]), 64'd4);
        end else begin
            chk("tp_pops", 64'(cpop_q.size()), 64'd4);
        end

        // random mix of sizes, offsets and core latencies
        for (int i = 0; i < 24; i++) begin
            ack_lat = $urandom_range(1, 4);
            rv_dly  = $urandom_range(1, 4);
            RFIFO_WFULL = ($urandom_range(0, 3) == 0);
            push_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     {24'd0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, $urandom(), 1'b1);
            step($urandom_range(0, 3));
            RFIFO_WFULL = 1'b0;
        end
        drain("rand", 2000);

        // reset while waiting for read data
        ack_lat = 1;
        rv_dly  = 20;
        r0 = n_ack;
        push_cmd(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (n_ack != r0) begin got = 1'b1; break; end
        end
        chk("mrst_ack", 64'(got), 64'd1);
        step(2);
        #1 HRESET = 1'b1;
        #1;
        chk("mrst_outs", {61'd0, MEM_REQ, BUSY, RFIFO_WEN}, 64'd0);
        chk("mrst_rdata", 64'(RFIFO_WDATA), 64'd0);
        exp_rd_q.delete();
        step(2);
        HRESET = 1'b0;
        step(1);
        rv_dly = 1;
        p0 = n_push;
        push_cmd(1'b0, 3'd2, 32'h0000_0020, 32'h0, 1'b1);
        drain("post_rst", 50);
        chk("post_rst_push", 64'(n_push - p0), 64'd1);

`ifdef SDRAM_SCHED_REFRESH_EN
        // refresh interleaving under continuous traffic
        r0 = n_ref;
        for (int i = 0; i < 16; i++) push_cmd(1'b1, 3'd2, {24'd0, 6'(i), 2'b00}, $urandom(), 1'b1);
        drain("ref", 1000);
        chk("ref_seen", 64'(n_ref > r0), 64'd1);
        chk("ref_gap", 64'(ref_gap_bad), 64'd0);
`else
        chk("no_refresh", 64'(n_ref), 64'd0);
`endif

        chk("flag_rules", 64'(n_flag_bad), 64'd0);
        chk("leftover", 64'(exp_q.size() + exp_rd_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_fifo_scheduler.md
# sdram_fifo_scheduler

Memory-side sequencer for the SDRAM command/data FIFOs. Pops one command from the command FIFO, fetches write data or collects read data, and drives a single-request handshake into the SDRAM core. Read results go back to the read FIFO. Sits between the three clock-domain FIFOs and the SDRAM core, and optionally interleaves periodic auto-refresh requests.

## Interface
- `ADDR_WIDTH`, 25: word-address width to the core; `MEM_ADDR = cmd[ADDR_WIDTH+1:2]`.
- `REFRESH_PERIOD`, 780: cycles between refresh requests; used only with the refresh macro.
- `HCLK` in 1: clock.
- `HRESET` in 1: asynchronous, active-high reset.
- `CFIFO_REN` out 1: pop command FIFO.
- `CFIFO_RDATA` in `SDRAM_CMD_FIFO_DATA_WIDTH` (36): command; [31:0] byte address, [34:32] size, [35] write.
- `CFIFO_REMPTY` in 1: command FIFO empty.
- `WFIFO_REN` out 1: pop write-data FIFO.
- `WFIFO_RDATA` in 32: write data.
- `WFIFO_REMPTY` in 1: write-data FIFO empty.
- `RFIFO_WEN` out 1: push read-data FIFO.
- `RFIFO_WDATA` out 32: read data.
- `RFIFO_WFULL` in 1: read FIFO full.
- `MEM_REQ` out 1: request to core, held until `MEM_ACK`.
- `MEM_WRITE` out 1: 1 = write, 0 = read.
- `MEM_REFRESH` out 1: request is an auto-refresh.
- `MEM_ADDR` out `ADDR_WIDTH`: word address.
- `MEM_BE` out 4: byte enables.
- `MEM_WDATA` out 32: write data.
- `MEM_ACK` in 1: core accepted the request (one-cycle pulse).
- `MEM_RDATA` in 32: read data.
- `MEM_RVALID` in 1: `MEM_RDATA` valid (one-cycle pulse).
- `BUSY` out 1: state is not S_IDLE.

## Operation
- All FIFOs are show-ahead: read data is valid while the FIFO is not empty, and REN pops the word.
- **S_IDLE**
  - If refresh is pending, go to S_REF.
  - Otherwise, if `!CFIFO_REMPTY`: assert `CFIFO_REN` and latch addr/size/write.
  - Then go to S_WDATA if write, else S_RD_REQ.
- **S_WDATA:** when `!WFIFO_REMPTY`, assert `WFIFO_REN`, latch `MEM_WDATA`, go to S_WR_REQ.
- **S_WR_REQ:** `MEM_REQ=1`, `MEM_WRITE=1`. On `MEM_ACK`, go to S_IDLE.
- **S_RD_REQ:** `MEM_REQ=1`, `MEM_WRITE=0`. On `MEM_ACK`, go to S_RD_DATA.
- **S_RD_DATA:** on `MEM_RVALID`, latch `MEM_RDATA` into `RFIFO_WDATA`, go to S_RD_PUSH. A `MEM_RVALID` in the same cycle as `MEM_ACK` is not accepted.
- **S_RD_PUSH:** when `!RFIFO_WFULL`, assert `RFIFO_WEN`, go to S_IDLE.
- **S_REF:** `MEM_REQ=1`, `MEM_REFRESH=1`. On `MEM_ACK`, clear pending and go to S_IDLE.
- `MEM_BE` by size:
  - size 0: `4'b0001 << addr[1:0]`
  - size 1: `addr[1] ? 4'b1100 : 4'b0011`
  - size 2 and all other codes: `4'b1111`
- `MEM_ADDR`, `MEM_BE` and `MEM_WDATA` are registered and held stable while `MEM_REQ` is high.
- `MEM_WRITE` and `MEM_REFRESH` are 0 outside their states.
- `MEM_REQ` is a decode of the registered state.
- `CFIFO_REN`, `WFIFO_REN` and `RFIFO_WEN` are combinational from the state and the FIFO flags.
- Exactly one command is in flight at a time. Commands complete strictly in FIFO order.

## Timing
- **Reset:**
  - State goes to S_IDLE.
  - All outputs are 0, including `MEM_ADDR`, `MEM_BE`, `MEM_WDATA` and `RFIFO_WDATA`.
  - Refresh counter and pending flag are cleared.
- **Reset mid-operation:** `MEM_REQ` drops immediately and any popped command or data is discarded. The FIFOs and the core are reset by the same system reset.
- **Write latency:** command present in S_IDLE at cycle 0 gives `CFIFO_REN` at cycle 0. With write data present, `WFIFO_REN` is at cycle 1 and `MEM_REQ` at cycle 2.
- **Read latency:** `MEM_REQ` at cycle 1. `RFIFO_WEN` comes 1 cycle after `MEM_RVALID` if the read FIFO is not full.
- **Return to idle:** the next command may pop in the cycle after the ACK for writes, or after the push for reads. Minimum is 3 cycles per write and 4 per read, with zero core latency.
- **Back-pressure:** an empty write FIFO or a full read FIFO stalls in place for any number of cycles.

## Configuration
- **`SDRAM_SCHED_REFRESH_EN` defined:**
  - A free-running counter runs 0..`REFRESH_PERIOD-1`; wrapping sets the sticky pending flag.
  - A second wrap while still pending is not counted.
  - Pending takes priority over a waiting command, but only in S_IDLE. It never interrupts a command.
- **`SDRAM_SCHED_REFRESH_EN` undefined:** no counter and no S_REF; `MEM_REFRESH` is tied to 0. The core handles refresh itself.

## Test plan
- **Write word:** cmd {write=1, size=2, addr=0x0000_0104}, WFIFO 0xDEADBEEF, ACK after 3 cycles → `MEM_ADDR=0x41`, `MEM_BE=1111`, `MEM_WDATA=0xDEADBEEF`, `MEM_REQ` high exactly 3 cycles. WFIFO popped once.
- **Read byte:** cmd {write=0, size=0, addr=0x0000_0003}, RVALID with 0x11223344 two cycles after ACK → `MEM_BE=1000`, `RFIFO_WEN` one cycle after RVALID with `RFIFO_WDATA=0x11223344`.
- **Back-pressure:** write cmd with WFIFO empty for 5 cycles → `MEM_REQ` stays 0 for the 5 cycles and `WFIFO_REN` fires when data arrives. A read with `RFIFO_WFULL` high for 4 cycles → `RFIFO_WEN` is held until full drops.
- **Ordering:** 3 queued cmds (W 0x10, R 0x10, W 0x20) → core sees them in the same order, one `MEM_REQ` each, and the read returns the written data (core model).
- **Refresh (macro on, `REFRESH_PERIOD=16`):** continuous commands → `MEM_REFRESH` request every ≥16 cycles, issued only between commands. Pending is cleared on ACK.
- **Reset:** assert `HRESET` while in S_RD_DATA → `MEM_REQ`, `BUSY` and `RFIFO_WEN` go low immediately. After release, the next queued command is processed normally.
